// File: rtl/sirv_cdc_pkg.sv
// rtl/sirv_cdc_pkg.sv - shared Gray-code helpers for the async queue ends
package sirv_cdc_pkg;

  localparam int GW = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sirv_sync_vec.sv
// rtl/sirv_sync_vec.sv - W-bit multi-flop synchronizer chain, async reset to 0
module sirv_sync_vec #(
  parameter int W    = 1,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [SYNC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC-1];

endmodule

// File: rtl/sirv_async_queue_sink.sv
// rtl/sirv_async_queue_sink.sv - sink end of a Gray-indexed clock-domain-crossing queue
module sirv_async_queue_sink
  import sirv_cdc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int SYNC  = 3,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW:0]         widx_gray,
  input  logic [DEPTH*DW-1:0] mem_flat,
  output logic [AW:0]         ridx_gray,
  output logic                deq_valid,
  input  logic                deq_ready,
  output logic [DW-1:0]       deq_bits
);

  logic [AW:0]   widx_sync;
  logic [AW:0]   ridx_bin;
  logic [AW:0]   ridx_next;
  logic [AW:0]   widx_bin;
  logic [AW:0]   occupancy;
  logic          empty;
  logic          load;
  logic [DW-1:0] entry;

  sirv_sync_vec #(.W(AW + 1), .SYNC(SYNC)) u_widx_sync (
    .clk (clk),
    .rst (rst),
    .d   (widx_gray),
    .q   (widx_sync)
  );

  // Gray codes compare equal exactly when binary indices do, wrap bit included.
  assign empty     = (ridx_gray == widx_sync);
  assign load      = !empty && (!deq_valid || deq_ready);
  assign ridx_next = ridx_bin + {{AW{1'b0}}, 1'b1};
  assign entry     = mem_flat[ridx_bin[AW-1:0]*DW +: DW];

  // The slot is released at load time; deq_bits keeps its own copy of the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ridx_bin  <= '0;
      ridx_gray <= '0;
      deq_valid <= 1'b0;
      deq_bits  <= '0;
    end else if (load) begin
      deq_bits  <= entry;
      deq_valid <= 1'b1;
      ridx_bin  <= ridx_next;
      ridx_gray <= (AW + 1)'(bin2gray(GW'(ridx_next)));
    end else if (deq_valid && deq_ready) begin
      deq_valid <= 1'b0;
    end
  end

  assign widx_bin  = (AW + 1)'(gray2bin(GW'(widx_sync)));
  assign occupancy = widx_bin - ridx_bin;

  a_widx_legal: assert property (@(posedge clk) disable iff (rst)
    occupancy <= (AW + 1)'(DEPTH));

endmodule

// File: tb/tb_sirv_async_queue_sink.sv
// tb/tb_sirv_async_queue_sink.sv - directed vector bench for sirv_async_queue_sink
module tb_sirv_async_queue_sink;

  logic          clk;
  logic          rst;
  logic [3:0]    widx_gray;
  logic [255:0]  mem_flat;
  logic [3:0]    ridx_gray;
  logic          deq_valid;
  logic          deq_ready;
  logic [31:0]   deq_bits;
  logic [31:0]   mem [8];

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic [3:0]  widx;
    logic        rdy;
    logic        vld;
    logic [31:0] bits;
    logic [3:0]  ridx;
  } vec_t;

  vec_t tbl [18];

  sirv_async_queue_sink #(.DW(32), .DEPTH(8), .SYNC(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .widx_gray (widx_gray),
    .mem_flat  (mem_flat),
    .ridx_gray (ridx_gray),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_bits  (deq_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < 8; i++) mem_flat[i*32 +: 32] = mem[i];
  end

  function automatic logic [3:0] g(input logic [3:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] x);
    logic [3:0] b;
    b[3] = x[3];
    b[2] = b[3] ^ x[2];
    b[1] = b[2] ^ x[1];
    b[0] = b[1] ^ x[0];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  wbin;
    logic [3:0]  occ;
    logic [3:0]  prev_gray;
    logic [31:0] q [$];
    logic [31:0] expv;
    logic        acc;
    logic        pv;
    logic        wrap_seen;
    logic        found;
    int          sent;
    int          rcvd;

    checks    = 0;
    failures  = 0;

    // Per-cycle vectors: inputs applied before the edge, outputs checked after it.
    tbl[0]  = '{1'b0, 4'h1, 1'b1, 1'b0, 32'h0,         4'h0};
    tbl[1]  = '{1'b0, 4'h1, 1'b1, 1'b0, 32'h0,         4'h0};
    tbl[2]  = '{1'b0, 4'h1, 1'b1, 1'b0, 32'h0,         4'h0};
    tbl[3]  = '{1'b0, 4'h1, 1'b1, 1'b1, 32'hA5A5_0001, 4'h1};
    tbl[4]  = '{1'b0, 4'h1, 1'b1, 1'b0, 32'hA5A5_0001, 4'h1};
    tbl[5]  = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0,         4'h0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 32'h0,         4'h0};
    tbl[7]  = '{1'b0, 4'h3, 1'b0, 1'b0, 32'h0,         4'h0};
    tbl[8]  = '{1'b0, 4'h3, 1'b0, 1'b0, 32'h0,         4'h0};
    tbl[9]  = '{1'b0, 4'h3, 1'b0, 1'b0, 32'h0,         4'h0};
    tbl[10] = '{1'b0, 4'h3, 1'b0, 1'b1, 32'hA5A5_0001, 4'h1};
    for (int i = 11; i < 16; i++) tbl[i] = '{1'b0, 4'h3, 1'b0, 1'b1, 32'hA5A5_0001, 4'h1};
    tbl[16] = '{1'b0, 4'h3, 1'b1, 1'b1, 32'h5A5A_0002, 4'h3};
    tbl[17] = '{1'b0, 4'h3, 1'b1, 1'b0, 32'h5A5A_0002, 4'h3};

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      widx_gray = 4'($urandom);
      deq_ready = 1'($urandom);
      for (int j = 0; j < 8; j++) mem[j] = $urandom;
      tick();
      chk("rst_valid", 32'(deq_valid), 32'h0);
      chk("rst_bits", deq_bits, 32'h0);
      chk("rst_ridx", 32'(ridx_gray), 32'h0);
    end
    for (int j = 0; j < 8; j++) mem[j] = 32'h0;
    mem[0] = 32'hA5A5_0001;
    mem[1] = 32'h5A5A_0002;
    rst = 1'b0;
    widx_gray = 4'h0;
    deq_ready = 1'b1;
    tick();
    chk("rel_valid", 32'(deq_valid), 32'h0);
    chk("rel_bits", deq_bits, 32'h0);
    chk("rel_ridx", 32'(ridx_gray), 32'h0);

    // Single entry, then backpressure after a reset
    for (int i = 0; i < 18; i++) begin
      rst       = tbl[i].rst;
      widx_gray = tbl[i].widx;
      deq_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(deq_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_bits", i), deq_bits, tbl[i].bits);
      chk($sformatf("vec%0d_ridx", i), 32'(ridx_gray), 32'(tbl[i].ridx));
    end

    // Full burst of 8
    rst = 1'b1;
    widx_gray = 4'h0;
    tick();
    rst = 1'b0;
    tick();
    for (int j = 0; j < 8; j++) mem[j] = 32'(j);
    widx_gray = 4'hC;
    deq_ready = 1'b1;
    for (int n = 0; n < 20 && !deq_valid; n++) tick();
    chk("burst_start", 32'(deq_valid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst%0d_valid", i), 32'(deq_valid), 32'h1);
      chk($sformatf("burst%0d_bits", i), deq_bits, 32'(i));
      tick();
    end
    chk("burst_end_valid", 32'(deq_valid), 32'h0);
    chk("burst_end_ridx", 32'(ridx_gray), 32'hC);

    // Wrap-around stream with source refilling and a patterned ready
    wbin      = 4'd8;
    prev_gray = ridx_gray;
    wrap_seen = 1'b0;
    sent      = 0;
    rcvd      = 0;
    for (int cyc = 0; cyc < 300 && rcvd < 20; cyc++) begin
      occ = wbin - g2b(ridx_gray);
      if (sent < 20 && occ < 4'd8) begin
        mem[wbin[2:0]] = 32'hC0DE_0000 + 32'(sent);
        q.push_back(32'hC0DE_0000 + 32'(sent));
        sent++;
        wbin = wbin + 4'd1;
        widx_gray = g(wbin);
      end
      deq_ready = (cyc % 3 != 2);
      acc = deq_valid && deq_ready;
      pv  = deq_valid;
      tick();
      if (deq_valid && (acc || !pv)) begin
        if (q.size() == 0) begin
          chk("stream_extra_beat", deq_bits, 32'hFFFF_FFFF);
        end else begin
          expv = q.pop_front();
          chk($sformatf("stream%0d_bits", rcvd), deq_bits, expv);
        end
        rcvd++;
      end
      if (ridx_gray != prev_gray) begin
        chk("ridx_step", 32'(ridx_gray), 32'(g(g2b(prev_gray) + 4'd1)));
        chk("ridx_onebit", 32'($countones(ridx_gray ^ prev_gray)), 32'h1);
        if (prev_gray == 4'h8 && ridx_gray == 4'h0) wrap_seen = 1'b1;
        prev_gray = ridx_gray;
      end
    end
    chk("stream_count", 32'(rcvd), 32'd20);
    chk("wrap_seen", 32'(wrap_seen), 32'h1);

    // Reset while holding entry3
    rst = 1'b1;
    widx_gray = 4'h0;
    tick();
    for (int j = 0; j < 4; j++) mem[j] = 32'hBEEF_0000 + 32'(j);
    rst = 1'b0;
    tick();
    widx_gray = g(4'd4);
    deq_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      tick();
      if (deq_valid && deq_bits == 32'hBEEF_0003) begin
        found = 1'b1;
        deq_ready = 1'b0;
      end
    end
    chk("hold3_found", 32'(found), 32'h1);
    tick();
    chk("hold3_valid", 32'(deq_valid), 32'h1);
    chk("hold3_bits", deq_bits, 32'hBEEF_0003);
    #2;
    rst = 1'b1;
    widx_gray = 4'h0;
    #1;
    chk("async_rst_valid", 32'(deq_valid), 32'h0);
    chk("async_rst_ridx", 32'(ridx_gray), 32'h0);
    chk("async_rst_bits", deq_bits, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    deq_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("no_stale_valid", 32'(deq_valid), 32'h0);
    end
    mem[0] = 32'hBEEF_0010;
    widx_gray = 4'h1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("lat_pre_valid", 32'(deq_valid), 32'h0);
    end
    tick();
    chk("lat_k3_valid", 32'(deq_valid), 32'h1);
    chk("lat_k3_bits", deq_bits, 32'hBEEF_0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
